// File: rtl/dti_global_parameters.sv
// -----------------------------------------------------------------------------
// dti_global_parameters: shared encodings and LSU state type. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package dti_global_parameters;

    localparam logic [2:0] MEMORY_TYPE_NONE          = 3'd0;
    localparam logic [2:0] MEMORY_TYPE_LOAD          = 3'd1;
    localparam logic [2:0] MEMORY_TYPE_LOAD_UNSIGNED = 3'd2;
    localparam logic [2:0] MEMORY_TYPE_STORE         = 3'd3;
    localparam logic [2:0] MEMORY_TYPE_INVALID       = 3'd4;

    localparam logic [1:0] MEMOP_SIZE_BYTE     = 2'd0;
    localparam logic [1:0] MEMOP_SIZE_HALFWORD = 2'd1;
    localparam logic [1:0] MEMOP_SIZE_WORD     = 2'd2;
    localparam logic [1:0] MEMOP_SIZE_RESERVED = 2'd3;

    localparam logic [5:0] CSR_CAUSE_INVALID_INSTR    = 6'd2;
    localparam logic [5:0] CSR_CAUSE_LOAD_MISALIGNED  = 6'd4;
    localparam logic [5:0] CSR_CAUSE_LOAD_ACCESS_FAULT  = 6'd5;
    localparam logic [5:0] CSR_CAUSE_STORE_MISALIGNED = 6'd6;
    localparam logic [5:0] CSR_CAUSE_STORE_ACCESS_FAULT = 6'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            MEMOP_SIZE_HALFWORD: return addr_lo[0];
            MEMOP_SIZE_WORD:     return addr_lo != 2'b00;
            default:             return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_lsu_align.sv
// -----------------------------------------------------------------------------
// riscv_lsu_align: byte enables, store lane replication, load extraction. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module riscv_lsu_align
    import dti_global_parameters::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    always_comb begin
        shifted     = rdata >> {addr_lo, 3'b000};
        be          = 4'hF;
        wdata_lanes = wdata;
        rdata_ext   = shifted;
        case (size)
            MEMOP_SIZE_BYTE: begin
                be          = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = is_unsigned ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            end
            MEMOP_SIZE_HALFWORD: begin
                be          = 4'b0011 << addr_lo;
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = is_unsigned ? {16'b0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/riscv_lsu_controller.sv
// -----------------------------------------------------------------------------
// riscv_lsu_controller: one-at-a-time load/store sequencer on a req/gnt/rvalid bus. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module riscv_lsu_controller
    import dti_global_parameters::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  mem_op,
    input  logic [1:0]  mem_size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_exception,
    output logic [5:0]  resp_cause,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    localparam int            CW           = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_t    state_q, state_d;
    logic [2:0]    op_q;
    logic [1:0]    size_q;
    logic [31:0]   addr_q, wdata_q;
    logic [CW-1:0] cnt_q;

    logic        latch, set_resp, resp_exc_d;
    logic [5:0]  resp_cause_d;
    logic [31:0] resp_rdata_d;
    logic [3:0]  be;
    logic [31:0] wdata_lanes, rdata_ext;

    wire is_load_in  = (mem_op == MEMORY_TYPE_LOAD) || (mem_op == MEMORY_TYPE_LOAD_UNSIGNED);
    wire is_store_in = (mem_op == MEMORY_TYPE_STORE);
    wire store_q     = (op_q == MEMORY_TYPE_STORE);
    wire in_req      = (state_q == REQ);
    wire timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_LAST);

    riscv_lsu_align u_align (
        .size        (size_q),
        .addr_lo     (addr_q[1:0]),
        .is_unsigned (op_q == MEMORY_TYPE_LOAD_UNSIGNED),
        .wdata       (wdata_q),
        .rdata       (bus_rdata),
        .be          (be),
        .wdata_lanes (wdata_lanes),
        .rdata_ext   (rdata_ext)
    );

    always_comb begin
        state_d      = state_q;
        latch        = 1'b0;
        set_resp     = 1'b0;
        resp_exc_d   = 1'b0;
        resp_cause_d = '0;
        resp_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (req_valid && mem_op != MEMORY_TYPE_NONE) begin
                    if (!(is_load_in || is_store_in) || mem_size == MEMOP_SIZE_RESERVED) begin
                        set_resp     = 1'b1;
                        resp_exc_d   = 1'b1;
                        resp_cause_d = CSR_CAUSE_INVALID_INSTR;
                    end else if (is_misaligned(mem_size, addr[1:0])) begin
                        set_resp     = 1'b1;
                        resp_exc_d   = 1'b1;
                        resp_cause_d = is_store_in ? CSR_CAUSE_STORE_MISALIGNED
                                                   : CSR_CAUSE_LOAD_MISALIGNED;
                    end else begin
                        latch   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus_gnt) state_d = WAIT;
            end
            WAIT: begin
                // A response arriving on the timeout cycle still counts as a response.
                if (bus_rvalid) begin
                    set_resp = 1'b1;
                    if (bus_err) begin
                        resp_exc_d   = 1'b1;
                        resp_cause_d = store_q ? CSR_CAUSE_STORE_ACCESS_FAULT
                                               : CSR_CAUSE_LOAD_ACCESS_FAULT;
                    end else if (!store_q) begin
                        resp_rdata_d = rdata_ext;
                    end
                end else if (timeout_hit) begin
                    set_resp     = 1'b1;
                    resp_exc_d   = 1'b1;
                    resp_cause_d = store_q ? CSR_CAUSE_STORE_ACCESS_FAULT
                                           : CSR_CAUSE_LOAD_ACCESS_FAULT;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (set_resp) state_d = RESP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            op_q           <= MEMORY_TYPE_NONE;
            size_q         <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            cnt_q          <= '0;
            resp_rdata     <= '0;
            resp_exception <= 1'b0;
            resp_cause     <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                op_q    <= mem_op;
                size_q  <= mem_size;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            cnt_q <= (state_q == WAIT) ? cnt_q + 1'b1 : '0;
            if (set_resp) begin
                resp_rdata     <= resp_rdata_d;
                resp_exception <= resp_exc_d;
                resp_cause     <= resp_cause_d;
            end else if (state_q == RESP) begin
                resp_rdata     <= '0;
                resp_exception <= 1'b0;
                resp_cause     <= '0;
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign stall      = !req_ready;
    assign resp_valid = (state_q == RESP);
    assign bus_req    = in_req;
    assign bus_we     = in_req && store_q;
    assign bus_addr   = in_req ? {addr_q[31:2], 2'b00} : '0;
    assign bus_be     = in_req ? be : '0;
    assign bus_wdata  = bus_we ? wdata_lanes : '0;

endmodule

`default_nettype wire

// File: tb/tb_riscv_lsu_controller.sv
// -----------------------------------------------------------------------------
// tb_riscv_lsu_controller: directed vector table plus hand-written corner sequences. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_riscv_lsu_controller;
    import dti_global_parameters::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, stall, resp_valid, resp_exception;
    logic [2:0]  mem_op;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata, resp_rdata, bus_addr, bus_wdata, bus_rdata;
    logic [5:0]  resp_cause;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid, bus_err;
    logic [3:0]  bus_be;

    always #5 clk = ~clk;

    riscv_lsu_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .mem_op(mem_op), .mem_size(mem_size), .addr(addr), .wdata(wdata),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_exception(resp_exception), .resp_cause(resp_cause),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gnt_dly;
        int          rv_dly;     // WAIT cycle carrying rvalid (1 = first); 0 = never
        logic [31:0] rdata;
        logic        err;
        logic        exp_bus;
        logic [3:0]  exp_be;
        logic [31:0] exp_baddr;
        logic [31:0] exp_bwdata;
        logic [31:0] exp_rdata;
        logic        exp_exc;
        logic [5:0]  exp_cause;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    task automatic idle_inputs();
        req_valid  = 1'b0;
        mem_op     = MEMORY_TYPE_NONE;
        mem_size   = MEMOP_SIZE_BYTE;
        addr       = '0;
        wdata      = '0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_err    = 1'b0;
        bus_rdata  = '0;
    endtask

    // Entered and left on a falling edge; acceptance happens at the next rising edge.
    task automatic run_vec(input vec_t v, input string tag);
        int   gnt_at   = -1;
        int   resp_at  = -1;
        int   req_seen = 0;
        logic bus_seen = 1'b0;
        mem_op = v.op; mem_size = v.size; addr = v.addr; wdata = v.wdata; req_valid = 1'b1;
        for (int i = 1; i <= 12 && resp_at < 0; i++) begin
            @(negedge clk);
            idle_inputs();
            if (bus_req) begin
                if (!bus_seen) begin
                    check({tag, " bus_be"},    {28'b0, bus_be}, {28'b0, v.exp_be});
                    check({tag, " bus_addr"},  bus_addr, v.exp_baddr);
                    check({tag, " bus_wdata"}, bus_wdata, v.exp_bwdata);
                    check({tag, " bus_we"},    {31'b0, bus_we}, {31'b0, v.op == MEMORY_TYPE_STORE});
                end
                bus_seen = 1'b1;
                if (req_seen == v.gnt_dly) begin
                    bus_gnt = 1'b1;
                    gnt_at  = i;
                end
                req_seen++;
            end else if (gnt_at > 0 && v.rv_dly > 0 && i - gnt_at == v.rv_dly) begin
                bus_rvalid = 1'b1;
                bus_rdata  = v.rdata;
                bus_err    = v.err;
            end
            if (resp_valid) begin
                resp_at = i;
                check({tag, " resp_rdata"}, resp_rdata, v.exp_rdata);
                check({tag, " resp_exception"}, {31'b0, resp_exception}, {31'b0, v.exp_exc});
                check({tag, " resp_cause"}, {26'b0, resp_cause}, {26'b0, v.exp_cause});
            end
        end
        check({tag, " bus_used"}, {31'b0, bus_seen}, {31'b0, v.exp_bus});
        check({tag, " latency"}, resp_at, v.exp_lat);
        @(negedge clk);
        check({tag, " resp_pulse_end"}, {31'b0, resp_valid}, 32'd0);
        check({tag, " ready_back"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        //          op                         size                 addr          wdata         gd rv rdata          err bus be       baddr         bwdata        rdata          exc cause                        lat
        vecs[0]  = '{MEMORY_TYPE_LOAD,          MEMOP_SIZE_BYTE,     32'h0000_1003, 32'h0,        0, 1, 32'h80FF_FF12, 0,  1, 4'b1000, 32'h0000_1000, 32'h0,        32'hFFFF_FF80, 0, 6'd0,                         3};
        vecs[1]  = '{MEMORY_TYPE_LOAD_UNSIGNED, MEMOP_SIZE_HALFWORD, 32'h0000_2002, 32'h0,        0, 1, 32'hBEEF_0000, 0,  1, 4'b1100, 32'h0000_2000, 32'h0,        32'h0000_BEEF, 0, 6'd0,                         3};
        vecs[2]  = '{MEMORY_TYPE_STORE,         MEMOP_SIZE_BYTE,     32'h0000_1001, 32'h0000_00AB, 0, 1, 32'h0,        0,  1, 4'b0010, 32'h0000_1000, 32'hABAB_ABAB, 32'h0,        0, 6'd0,                         3};
        vecs[3]  = '{MEMORY_TYPE_STORE,         MEMOP_SIZE_WORD,     32'h0000_3002, 32'h1111_2222, 0, 1, 32'h0,        0,  0, 4'b0000, 32'h0,         32'h0,        32'h0,        1, 6'd6,                         1};
        vecs[4]  = '{MEMORY_TYPE_INVALID,       MEMOP_SIZE_WORD,     32'h0000_4000, 32'h0,        0, 1, 32'h0,        0,  0, 4'b0000, 32'h0,         32'h0,        32'h0,        1, CSR_CAUSE_INVALID_INSTR,      1};
        vecs[5]  = '{MEMORY_TYPE_LOAD,          MEMOP_SIZE_HALFWORD, 32'h0000_1001, 32'h0,        0, 1, 32'h0,        0,  0, 4'b0000, 32'h0,         32'h0,        32'h0,        1, 6'd4,                         1};
        vecs[6]  = '{MEMORY_TYPE_LOAD,          MEMOP_SIZE_WORD,     32'h0000_4000, 32'h0,        0, 0, 32'h0,        0,  1, 4'b1111, 32'h0000_4000, 32'h0,        32'h0,        1, 6'd5,                         6};
        vecs[7]  = '{MEMORY_TYPE_STORE,         MEMOP_SIZE_HALFWORD, 32'h0000_5002, 32'h1234_5678, 0, 1, 32'h0,        1,  1, 4'b1100, 32'h0000_5000, 32'h5678_5678, 32'h0,        1, 6'd7,                         3};
        vecs[8]  = '{MEMORY_TYPE_LOAD,          MEMOP_SIZE_WORD,     32'h0000_6004, 32'h0,        0, 4, 32'hDEAD_BEEF, 0,  1, 4'b1111, 32'h0000_6004, 32'h0,        32'hDEAD_BEEF, 0, 6'd0,                         6};
        vecs[9]  = '{MEMORY_TYPE_LOAD,          MEMOP_SIZE_HALFWORD, 32'h0000_7000, 32'h0,        2, 2, 32'h1234_8001, 0,  1, 4'b0011, 32'h0000_7000, 32'h0,        32'hFFFF_8001, 0, 6'd0,                         6};
        vecs[10] = '{MEMORY_TYPE_LOAD_UNSIGNED, MEMOP_SIZE_BYTE,     32'h0000_8002, 32'h0,        0, 1, 32'h00A5_0000, 0,  1, 4'b0100, 32'h0000_8000, 32'h0,        32'h0000_00A5, 0, 6'd0,                         3};

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst req_ready",  {31'b0, req_ready}, 32'd1);
        check("rst stall",      {31'b0, stall}, 32'd0);
        check("rst bus_req",    {31'b0, bus_req}, 32'd0);
        check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        check("rst resp_cause", {26'b0, resp_cause}, 32'd0);
        check("rst bus_be",     {28'b0, bus_be}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 11; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // mem_op NONE is not an operation: the controller stays idle.
        mem_op = MEMORY_TYPE_NONE; mem_size = MEMOP_SIZE_WORD; addr = 32'h100; req_valid = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("none req_ready", {31'b0, req_ready}, 32'd1);
        check("none bus_req",   {31'b0, bus_req}, 32'd0);
        check("none resp",      {31'b0, resp_valid}, 32'd0);

        // Grant withheld for five cycles while execute keeps offering another op.
        mem_op = MEMORY_TYPE_LOAD; mem_size = MEMOP_SIZE_WORD; addr = 32'h0000_9000; req_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            mem_op = MEMORY_TYPE_STORE; addr = 32'h0000_A000; wdata = 32'hFFFF_FFFF; req_valid = 1'b1;
            check($sformatf("hold%0d bus_req", k),   {31'b0, bus_req}, 32'd1);
            check($sformatf("hold%0d bus_addr", k),  bus_addr, 32'h0000_9000);
            check($sformatf("hold%0d bus_be", k),    {28'b0, bus_be}, 32'hF);
            check($sformatf("hold%0d bus_we", k),    {31'b0, bus_we}, 32'd0);
            check($sformatf("hold%0d stall", k),     {31'b0, stall}, 32'd1);
            check($sformatf("hold%0d req_ready", k), {31'b0, req_ready}, 32'd0);
        end
        @(negedge clk);
        idle_inputs();
        bus_gnt = 1'b1;
        @(negedge clk);
        idle_inputs();
        bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        idle_inputs();
        check("hold resp_valid", {31'b0, resp_valid}, 32'd1);
        check("hold resp_rdata", resp_rdata, 32'h0BAD_F00D);
        @(negedge clk);
        check("hold no_replay", {31'b0, bus_req}, 32'd0);
        check("hold idle",      {31'b0, req_ready}, 32'd1);

        // Asynchronous reset while a load waits for its response.
        mem_op = MEMORY_TYPE_LOAD; mem_size = MEMOP_SIZE_WORD; addr = 32'h0000_B000; req_valid = 1'b1;
        @(negedge clk);
        idle_inputs();
        bus_gnt = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("arst in_wait stall", {31'b0, stall}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst stall",      {31'b0, stall}, 32'd0);
        check("arst req_ready",  {31'b0, req_ready}, 32'd1);
        check("arst bus_req",    {31'b0, bus_req}, 32'd0);
        check("arst resp_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'h5555_5555;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            idle_inputs();
            check($sformatf("arst late%0d resp_valid", k), {31'b0, resp_valid}, 32'd0);
        end
        run_vec(vecs[0], "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
